// File: rtl/simd_wb_write_drain.sv
// Write-back drain: buffers multi-hot namespace write requests and serialises them into
// one-namespace-per-cycle scratchpad writes. Optional stall counter via SIMD_WB_STALL_CNT_EN.
module simd_wb_write_drain #(
    parameter int unsigned NS_ID_BITS        = 3,
    parameter int unsigned NS_INDEX_ID_BITS  = 5,
    parameter int unsigned BASE_STRIDE_WIDTH = 4 * (NS_INDEX_ID_BITS + NS_ID_BITS),
    parameter int unsigned NUM_NS            = 6,
    parameter int unsigned FIFO_DEPTH        = 8,
    parameter int unsigned AFULL_LEVEL       = 6,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_NS-1:0]            buf_wr_req_in,
    input  logic [BASE_STRIDE_WIDTH-1:0] buf_wr_addr_in,
    input  logic                         in_loop_in,
    output logic                         mem_wr_valid,
    input  logic                         mem_wr_ready,
    output logic [NS_ID_BITS-1:0]        mem_wr_ns,
    output logic [BASE_STRIDE_WIDTH-1:0] mem_wr_addr,
    output logic                         wb_afull,
    output logic                         wb_overflow,
    output logic                         wb_done,
    output logic [CNT_WIDTH-1:0]         wr_count
`ifdef SIMD_WB_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]         stall_cycles
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e                       state_q;
    logic [NUM_NS-1:0]            fifo_mask_q [FIFO_DEPTH];
    logic [BASE_STRIDE_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic [NUM_NS-1:0]            mask_q, mask_d;
    logic [BASE_STRIDE_WIDTH-1:0] addr_d;

    logic              accepting_c;
    logic              req_any_c;
    logic              fire_c;
    logic              fifo_empty_c;
    logic              fifo_full_c;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic              cnt_clr_c;
    logic [NUM_NS-1:0] low_onehot_c;
    logic [NUM_NS-1:0] mask_after_c;

    // Index of the lowest set bit; zero for an empty mask.
    function automatic logic [NS_ID_BITS-1:0] lsb_idx(input logic [NUM_NS-1:0] m);
        logic [NS_ID_BITS-1:0] idx;
        logic                  found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_NS; i++) begin
            if (m[i] && !found) begin
                idx   = NS_ID_BITS'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Dequeue may free a full slot in the same cycle, so the enqueue test includes pop_c.
    always_comb begin
        accepting_c  = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
        req_any_c    = |buf_wr_req_in;
        fire_c       = mem_wr_valid && mem_wr_ready;
        fifo_empty_c = (occ_q == '0);
        fifo_full_c  = (occ_q == OCC_W'(FIFO_DEPTH));
        low_onehot_c = mask_q & NUM_NS'(~mask_q + NUM_NS'(1));
        mask_after_c = fire_c ? (mask_q & ~low_onehot_c) : mask_q;
        pop_c        = (mask_after_c == '0) && !fifo_empty_c;
        push_c       = req_any_c && accepting_c && (!fifo_full_c || pop_c);
        drop_c       = req_any_c && accepting_c && fifo_full_c && !pop_c;
        cnt_clr_c    = (state_q == S_IDLE) && in_loop_in;

        mask_d   = mask_after_c;
        addr_d   = mem_wr_addr;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop_c) begin
            mask_d   = fifo_mask_q[rd_ptr_q];
            addr_d   = fifo_addr_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        occ_d = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
    end

    // FIFO storage carries no reset; validity is tracked by the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mask_q[wr_ptr_q] <= buf_wr_req_in;
            fifo_addr_q[wr_ptr_q] <= buf_wr_addr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            mask_q       <= '0;
            mem_wr_valid <= 1'b0;
            mem_wr_ns    <= '0;
            mem_wr_addr  <= '0;
            wb_afull     <= 1'b0;
            wb_overflow  <= 1'b0;
            wr_count     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            mask_q       <= mask_d;
            mem_wr_valid <= |mask_d;
            mem_wr_ns    <= lsb_idx(mask_d);
            mem_wr_addr  <= addr_d;
            wb_afull     <= (occ_d >= OCC_W'(AFULL_LEVEL));
            if (drop_c) begin
                wb_overflow <= 1'b1;
            end
            if (cnt_clr_c) begin
                wr_count <= '0;
            end else if (fire_c) begin
                wr_count <= wr_count + CNT_WIDTH'(1);
            end
        end
    end

    // Loop-activity state machine; wb_done is high exactly while in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wb_done <= 1'b0;
        end else begin
            wb_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_loop_in) begin
                        state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (!in_loop_in) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (in_loop_in) begin
                        state_q <= S_ACTIVE;
                    end else if (fifo_empty_c && (mask_q == '0) && !push_c) begin
                        state_q <= S_DONE;
                        wb_done <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SIMD_WB_STALL_CNT_EN
    // Backpressure cycles seen by a presented write, saturating.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr_c) begin
            stall_cycles <= '0;
        end else if (mem_wr_valid && !mem_wr_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_simd_wb_write_drain.sv
// Randomised and directed bench for simd_wb_write_drain against a queue-based reference model.
module tb_simd_wb_write_drain;

    localparam int unsigned NUM_NS = 6;
    localparam int unsigned AW     = 32;
    localparam int unsigned CW     = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AFULL  = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_NS-1:0] buf_wr_req_in = '0;
    logic [AW-1:0]     buf_wr_addr_in = '0;
    logic              in_loop_in = 1'b0;
    logic              mem_wr_ready = 1'b0;
    logic              mem_wr_valid;
    logic [2:0]        mem_wr_ns;
    logic [AW-1:0]     mem_wr_addr;
    logic              wb_afull;
    logic              wb_overflow;
    logic              wb_done;
    logic [CW-1:0]     wr_count;
`ifdef SIMD_WB_STALL_CNT_EN
    logic [CW-1:0]     stall_cycles;
`endif

    simd_wb_write_drain dut (
        .clk            (clk),
        .reset          (reset),
        .buf_wr_req_in  (buf_wr_req_in),
        .buf_wr_addr_in (buf_wr_addr_in),
        .in_loop_in     (in_loop_in),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_ready   (mem_wr_ready),
        .mem_wr_ns      (mem_wr_ns),
        .mem_wr_addr    (mem_wr_addr),
        .wb_afull       (wb_afull),
        .wb_overflow    (wb_overflow),
        .wb_done        (wb_done),
        .wr_count       (wr_count)
`ifdef SIMD_WB_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending request entries and the expanded write list of the current one.
    typedef struct {
        logic [NUM_NS-1:0] m;
        logic [AW-1:0]     a;
    } ent_t;

    ent_t          m_fifo[$];
    int            m_cur[$];
    logic [AW-1:0] m_addr;
    int            m_state;   // 0 idle, 1 active, 2 drain, 3 done
    logic [CW-1:0] m_cnt;
    bit            m_ovf;
    bit            m_done;

    int            obs_ns[$];
    logic [AW-1:0] obs_addr[$];
    int            done_seen;

    task automatic model_reset();
        m_fifo.delete();
        m_cur.delete();
        m_addr  = '0;
        m_state = 0;
        m_cnt   = '0;
        m_ovf   = 0;
        m_done  = 0;
    endtask

    task automatic model_step();
        bit   acc, pre_empty, pushed;
        ent_t e;
        if (reset) begin
            model_reset();
            return;
        end
        acc       = (m_state == 1) || (m_state == 2);
        pre_empty = (m_fifo.size() == 0) && (m_cur.size() == 0);
        if (m_cur.size() > 0 && mem_wr_ready) begin
            void'(m_cur.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        if (m_cur.size() == 0 && m_fifo.size() > 0) begin
            e = m_fifo.pop_front();
            for (int n = 0; n < NUM_NS; n++) if (e.m[n]) m_cur.push_back(n);
            m_addr = e.a;
        end
        pushed = 0;
        if (buf_wr_req_in != 0 && acc) begin
            if (m_fifo.size() < DEPTH) begin
                e.m = buf_wr_req_in;
                e.a = buf_wr_addr_in;
                m_fifo.push_back(e);
                pushed = 1;
            end else begin
                m_ovf = 1;
            end
        end
        m_done = 0;
        case (m_state)
            0: if (in_loop_in) begin m_state = 1; m_cnt = '0; end
            1: if (!in_loop_in) m_state = 2;
            2: if (in_loop_in) m_state = 1;
               else if (pre_empty && !pushed) begin m_state = 3; m_done = 1; end
            default: m_state = 0;
        endcase
    endtask

    task automatic compare();
        check("valid", 64'(mem_wr_valid), 64'(m_cur.size() > 0));
        if (m_cur.size() > 0) begin
            check("ns", 64'(mem_wr_ns), 64'(m_cur[0]));
            check("addr", 64'(mem_wr_addr), 64'(m_addr));
        end
        check("afull", 64'(wb_afull), 64'(m_fifo.size() >= AFULL));
        check("overflow", 64'(wb_overflow), 64'(m_ovf));
        check("done", 64'(wb_done), 64'(m_done));
        check("wr_count", 64'(wr_count), 64'(m_cnt));
    endtask

    // One clock: drive at negedge, step model on posedge, check at the next negedge.
    task automatic cycle(input logic rst, input logic [NUM_NS-1:0] req, input logic [AW-1:0] addr,
                         input logic loop, input logic rdy);
        reset          = rst;
        buf_wr_req_in  = req;
        buf_wr_addr_in = addr;
        in_loop_in     = loop;
        mem_wr_ready   = rdy;
        if (!rst && mem_wr_valid && rdy) begin
            obs_ns.push_back(int'(mem_wr_ns));
            obs_addr.push_back(mem_wr_addr);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (wb_done) done_seen++;
        compare();
    endtask

    task automatic start_test();
        cycle(1'b1, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        obs_ns.delete();
        obs_addr.delete();
        done_seen = 0;
    endtask

    initial begin
        logic loop_r;
        logic rdy_r;
        model_reset();
        done_seen = 0;
        @(negedge clk);
        cycle(1'b1, '0, '0, 1'b0, 1'b0);
        cycle(1'b1, '0, '0, 1'b0, 1'b0);
        check("rst_valid", 64'(mem_wr_valid), 64'd0);
        check("rst_ns", 64'(mem_wr_ns), 64'd0);
        check("rst_addr", 64'(mem_wr_addr), 64'd0);
        check("rst_count", 64'(wr_count), 64'd0);

        // Single write
        start_test();
        cycle(1'b0, 6'b000100, 32'hA5A5_0001, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        check("single_valid", 64'(mem_wr_valid), 64'd1);
        check("single_ns", 64'(mem_wr_ns), 64'd2);
        check("single_addr", 64'(mem_wr_addr), 64'hA5A5_0001);
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        check("single_count", 64'(wr_count), 64'd1);

        // Multi-hot serialisation
        start_test();
        cycle(1'b0, 6'b101001, 32'h1234_5678, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, '0, '0, 1'b1, 1'b1);
        check("multi_n", 64'(obs_ns.size()), 64'd3);
        if (obs_ns.size() == 3) begin
            check("multi_ns0", 64'(obs_ns[0]), 64'd0);
            check("multi_ns1", 64'(obs_ns[1]), 64'd3);
            check("multi_ns2", 64'(obs_ns[2]), 64'd5);
            check("multi_addr", 64'(obs_addr[2]), 64'h1234_5678);
        end
        check("multi_count", 64'(wr_count), 64'd3);

        // Backpressure and overflow
        start_test();
        for (int i = 0; i < 10; i++) cycle(1'b0, NUM_NS'(1 << (i % 6)), AW'(i), 1'b1, 1'b0);
        check("bp_overflow", 64'(wb_overflow), 64'd1);
        check("bp_afull", 64'(wb_afull), 64'd1);
        repeat (14) cycle(1'b0, '0, '0, 1'b1, 1'b1);
        check("bp_n", 64'(obs_addr.size()), 64'd9);
        for (int i = 0; i < obs_addr.size() && i < 9; i++) check("bp_order", 64'(obs_addr[i]), 64'(i));
        check("bp_overflow_sticky", 64'(wb_overflow), 64'd1);

        // Drain completion
        start_test();
        for (int i = 0; i < 4; i++) cycle(1'b0, NUM_NS'(1 << i), AW'(32'h100 + i), 1'b1, 1'b0);
        repeat (12) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check("drain_done_pulses", 64'(done_seen), 64'd1);
        check("drain_count", 64'(wr_count), 64'd4);
        check("drain_idle", 64'(m_state), 64'd0);

        // Full with simultaneous push and pop
        start_test();
        for (int i = 0; i < 9; i++) cycle(1'b0, 6'b000001, AW'(32'h200 + i), 1'b1, 1'b0);
        cycle(1'b0, 6'b000010, 32'h0000_0209, 1'b1, 1'b1);
        check("full_pp_overflow", 64'(wb_overflow), 64'd0);
        check("full_pp_occ", 64'(m_fifo.size()), 64'd8);
        repeat (14) cycle(1'b0, '0, '0, 1'b1, 1'b1);
        check("full_pp_total", 64'(obs_addr.size()), 64'd10);

        // Reset mid-drain
        start_test();
        for (int i = 0; i < 5; i++) cycle(1'b0, 6'b000011, AW'(32'h300 + i), 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b1, '0, '0, 1'b0, 1'b1);
        check("rmid_valid", 64'(mem_wr_valid), 64'd0);
        check("rmid_count", 64'(wr_count), 64'd0);
`ifdef SIMD_WB_STALL_CNT_EN
        check("rmid_stall", 64'(stall_cycles), 64'd0);
`endif
        obs_ns.delete();
        obs_addr.delete();
        repeat (15) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check("rmid_no_write", 64'(obs_addr.size()), 64'd0);

        // Randomised run
        start_test();
        loop_r = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) loop_r = ~loop_r;
            if (((i / 150) % 2) == 1) rdy_r = ($urandom_range(0, 9) < 2);
            else                      rdy_r = ($urandom_range(0, 9) < 8);
            cycle(($urandom_range(0, 399) == 0),
                  ($urandom_range(0, 1) == 1) ? NUM_NS'($urandom) : '0,
                  AW'($urandom), loop_r, rdy_r);
        end
        repeat (30) cycle(1'b0, '0, '0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
